// File: rtl/sseg_scan_ctrl_if.sv
// sseg_scan_ctrl_if: bus between a display-value producer and the scan controller.
//   value/dp/load  : new display value plus a one-cycle capture strobe
//   lzb_en         : leading-zero blanking enable (level)
//   digit_en       : one-hot digit select (PIN_1..PIN_4)
//   nibble/dp_out  : current digit's hex nibble and decimal point (to hex_to_sseg)
//   pending        : a loaded value is waiting for the next frame boundary
//   frame_tick     : pulse on the last cycle of digit 3's slot
// The master is the value producer; the slave is sseg_scan_ctrl.
interface sseg_scan_ctrl_if;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lzb_en;
  logic [3:0]  digit_en;
  logic [3:0]  nibble;
  logic        dp_out;
  logic        pending;
  logic        frame_tick;

  modport master (
    output value, dp, load, lzb_en,
    input  digit_en, nibble, dp_out, pending, frame_tick
  );

  modport slave (
    input  value, dp, load, lzb_en,
    output digit_en, nibble, dp_out, pending, frame_tick
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: 4-digit seven-segment time-multiplexing scheduler.
// Each digit gets DWELL cycles: BLANK_CYCLES with every select off (covers
// segment settling and the one-cycle hex_to_sseg latency), then the digit's
// select is driven for the rest of the slot. New values go into a shadow
// register and are copied to the active register only at the frame boundary,
// so a frame never mixes old and new digits.
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : sseg_scan_ctrl_if.slave (value/dp/load/lzb_en in; digit_en,
//           nibble, dp_out, pending, frame_tick out)
module sseg_scan_ctrl #(
  parameter int CLK_FREQ     = 16_000_000,
  parameter int FRAME_HZ     = 250,
  parameter int BLANK_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  sseg_scan_ctrl_if.slave   bus
);
  localparam int DWELL = CLK_FREQ / (FRAME_HZ * 4);
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow_val, active_val;
  logic [3:0]    shadow_dp,  active_dp;
  logic          pending_q;
  logic [3:0]    nibble_q;
  logic          dp_q;
  logic [3:0]    supp;
  logic [3:0]    digit_en_c;

  logic          slot_end, frame_end;
  logic [1:0]    idx_nx;
  logic [15:0]   active_val_nx;
  logic [3:0]    active_dp_nx;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);
  assign idx_nx    = idx + 2'd1;

  // Value the active register will hold after this edge; the nibble/dp for
  // the next slot are picked from it so digit 0 of a new frame already sees
  // the freshly applied value.
  assign active_val_nx = (frame_end && pending_q) ? shadow_val : active_val;
  assign active_dp_nx  = (frame_end && pending_q) ? shadow_dp  : active_dp;

  // Leading-zero suppression per digit, from the active register only.
  // Digit 0 always shows, so an all-zero value still displays "0".
  for (genvar g = 0; g < 4; g++) begin : g_supp
    if (g == 0) begin : g_d0
      assign supp[g] = 1'b0;
    end else begin : g_dn
      assign supp[g] = bus.lzb_en && (active_val[15:4*g] == '0);
    end
  end

  // Slot counter, digit index, shadow/active registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= 2'd0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending_q  <= 1'b0;
      nibble_q   <= '0;
      dp_q       <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx      <= idx_nx;
        nibble_q <= active_val_nx[{idx_nx, 2'b00} +: 4];
        dp_q     <= active_dp_nx[idx_nx];
      end
      active_val <= active_val_nx;
      active_dp  <= active_dp_nx;
      // A load on the boundary cycle lands in the shadow after the copy
      // above took the old shadow, so pending stays set for one more frame.
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp;
        pending_q  <= 1'b1;
      end else if (frame_end) begin
        pending_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    digit_en_c = 4'b0000;
    case (state)
      ST_BLANK: if (cnt == BLANK_LAST) state_nx = ST_ON;
      ST_ON: begin
        if (!supp[idx]) digit_en_c = 4'b0001 << idx;
        if (slot_end)   state_nx   = ST_BLANK;
      end
      default: state_nx = ST_BLANK;
    endcase
  end

  assign bus.digit_en   = digit_en_c;
  assign bus.nibble     = nibble_q;
  assign bus.dp_out     = dp_q;
  assign bus.pending    = pending_q;
  assign bus.frame_tick = frame_end;
endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Time-multiplexing scheduler for the shared 4-digit seven-segment bus. Each frame it steps through digits 0..3 in turn. For the selected digit it drives that digit's nibble and decimal point to the downstream hex_to_sseg decoder, and drives a one-hot active-high digit select onto PIN_1..PIN_4. New display values load through a double-buffered shadow register that is applied only at frame boundaries, so the display never shows a torn value. Each digit slot starts with a blanking interval to suppress ghosting while segments settle.

Parameters:
CLK_FREQ, 16_000_000, input clock frequency in Hz
FRAME_HZ, 250, full 4-digit refresh rate in Hz; DWELL = CLK_FREQ/(FRAME_HZ*4) cycles per digit slot (16000 at defaults)
BLANK_CYCLES, 64, cycles at the start of each slot with all digit selects off; must be >= 1 and < DWELL

Ports:
CLK        input   1   system clock, all state on rising edge
RST_N      input   1   asynchronous, active-low reset
value      input   16  display value; [3:0] is digit 0 (rightmost), [15:12] is digit 3
dp         input   4   decimal point per digit; bit i belongs to digit i
load       input   1   single-cycle strobe; captures value/dp into the shadow register
lzb_en     input   1   leading-zero blanking enable; level input, sampled live
digit_en   output  4   one-hot active-high digit select; 4'b0000 while blanking
nibble     output  4   hex nibble of the current digit, to hex_to_sseg
dp_out     output  1   decimal point of the current digit
pending    output  1   high while a loaded value waits for the next frame boundary
frame_tick output  1   one-cycle pulse on the last cycle of digit 3's slot

Behaviour:
- Reset (asynchronous, RST_N=0): digit_en=0, nibble=0, dp_out=0, pending=0, frame_tick=0. Shadow and active registers clear to 0. Digit index=0, slot counter=0, FSM=BLANK. Asserting reset mid-slot forces these values immediately. After release, scanning starts at digit 0, cycle 0 of BLANK.
- Slot counter runs 0..DWELL-1, then wraps to 0 and advances the digit index 0->1->2->3->0.
- FSM has two states:
  - BLANK: counter 0..BLANK_CYCLES-1; digit_en=0.
  - ON: counter BLANK_CYCLES..DWELL-1; digit_en=one-hot(index), unless the digit is suppressed.
  - Transitions: BLANK->ON when counter==BLANK_CYCLES-1. ON->BLANK (next digit) when counter==DWELL-1.
- nibble and dp_out are registered. They update on the first BLANK cycle of each slot and hold constant for the whole slot. hex_to_sseg has one cycle of latency, which the blanking interval absorbs.
- Load handshake:
  - load=1 writes value/dp into the shadow register and sets pending=1.
  - A load while pending=1 overwrites the shadow; the last write wins. No load is ever refused.
- Frame boundary (digit 3, counter==DWELL-1):
  - frame_tick=1.
  - If pending, active<=shadow and pending<=0, effective for digit 0 of the next frame.
  - If load arrives on this same cycle, active takes the pre-edge shadow. The new load lands in the shadow, pending stays 1, and it applies one frame later.
- Leading-zero blanking:
  - With lzb_en=1, digit i (i=1..3) is suppressed if active nibbles i..3 are all 0. A suppressed digit keeps digit_en=0 through its ON phase.
  - Digit 0 is never suppressed, so 0x0000 displays as "0".
  - dp is not considered: a suppressed digit's dp is not shown.
  - Suppression is evaluated on the active register only, never the shadow.
- The counter is wide enough for DWELL-1, with no overflow. The digit index wraps modulo 4.
- Nothing displays before the first load. Active is 0, so all digits show "0", or only digit 0 shows when lzb_en=1.

Test Plan:
All scenarios use CLK_FREQ=4000, FRAME_HZ=100, BLANK_CYCLES=2, so DWELL=10 and a frame is 40 cycles.
1. Release reset, no load -> digit_en sequence per slot: 2 cycles of 0000, then 8 cycles of 0001, then the same pattern with 0010, 0100, 1000. frame_tick pulses at cycles 39, 79. nibble=0 throughout.
2. load with value=16'h1A2F, dp=4'b0100 at cycle 5 -> pending=1 until cycle 39. From cycle 40: nibble=F,2,A,1 in slots 0..3. dp_out=1 only in digit 2's slot. pending=0 from cycle 40.
3. load 16'h1111 at cycle 12, then 16'h2222 at cycle 20 -> the next frame shows 2222 only; 1111 never appears.
4. load 16'h3333 exactly at cycle 39 (the frame_tick cycle) -> the frame starting at 40 still shows the old value, pending=1. 3333 appears from cycle 80.
5. lzb_en=1, active=16'h0050 -> digit_en stays 0000 in the slots for digits 3 and 2. Digits 1 and 0 are lit (5 and 0). With active=16'h0000, only digit 0 is lit.
6. Assert RST_N=0 at cycle 25, mid-ON of digit 2 -> digit_en=0000, pending=0, nibble=0 in the same cycle. After release, the scan restarts at digit 0 BLANK.
